// File: rtl/column_scheduler.sv
// Launch/respawn/tick sequencer for the three falling-letter columns.
// Every output is a register holding the value for the cycle it is visible in.
`timescale 1ns/1ps

module column_scheduler #(
  parameter int unsigned NUM_COLS       = 3,
  parameter int unsigned STAGGER_CYCLES = 25_000_000,
  parameter int unsigned BASE_PERIOD    = 50_000_000,
  parameter int unsigned MIN_PERIOD     = 10_000_000,
  parameter int unsigned PERIOD_STEP    = 2_000_000,
  parameter int unsigned SCORE_STEP     = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                game_start,
  input  logic                game_over_in,
  input  logic [NUM_COLS-1:0] respawn_req,
  input  logic [7:0]          score,
  output logic [NUM_COLS-1:0] col_reset,
  output logic [NUM_COLS-1:0] fall_tick,
  output logic                running,
  output logic [31:0]         fall_period
);

  localparam int unsigned IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int unsigned STG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;

  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_COLS - 1);
  localparam logic [STG_W-1:0]    STG_LAST = STG_W'(STAGGER_CYCLES - 1);
  localparam logic [NUM_COLS-1:0] ONE_COL  = NUM_COLS'(1);
  localparam logic [31:0]         BASE_P   = 32'(BASE_PERIOD);
  localparam logic [31:0]         MIN_P    = 32'(MIN_PERIOD);
  localparam logic [31:0]         SPAN     = 32'(BASE_PERIOD - MIN_PERIOD);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, HALT} state_t;

  state_t state_q, state_d;

  logic [NUM_COLS-1:0] active_q,  active_d;
  logic [NUM_COLS-1:0] pending_q, pending_d;
  logic [31:0]         tick_q,    tick_d;
  logic [STG_W-1:0]    stagger_q, stagger_d;
  logic [IDX_W-1:0]    idx_q,     idx_d;
  logic [31:0]         period_d;

  logic [NUM_COLS-1:0] col_reset_d, fall_tick_d;
  logic                running_d;

  logic                in_play, wrap, launch_slot;
  logic [7:0]          lvl;
  logic [31:0]         red, target;

  assign in_play     = (state_q == LAUNCH) || (state_q == RUN);
  assign wrap        = (tick_q == fall_period - 32'd1);
  assign launch_slot = (state_q == LAUNCH) && (stagger_q == '0);

  // Saturating difficulty ramp; only sampled on a wrap cycle.
  assign lvl    = score / 8'(SCORE_STEP);
  assign red    = 32'(lvl) * 32'(PERIOD_STEP);
  assign target = (red >= SPAN) ? MIN_P : BASE_P - red;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (game_start) begin
      state_d = LAUNCH;
    end else begin
      case (state_q)
        LAUNCH: begin
          if (game_over_in)                          state_d = HALT;
          else if (launch_slot && idx_q == LAST_IDX) state_d = RUN;
        end
        RUN:     if (game_over_in) state_d = HALT;
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next values: column bookkeeping and counters
  // ---------------------------------------------------------------------------
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    tick_d    = tick_q;
    stagger_d = stagger_q;
    idx_d     = idx_q;
    period_d  = fall_period;

    if (game_start) begin
      active_d  = '0;
      pending_d = '0;
      tick_d    = '0;
      stagger_d = '0;
      idx_d     = '0;
      period_d  = BASE_P;
    end else if (in_play) begin
      // col_reset is the pulse visible this cycle; its column goes live next cycle
      active_d = active_q | col_reset;
      if (game_over_in)
        pending_d = '0;
      else
        pending_d = (pending_q | (respawn_req & active_q)) & ~col_reset;

      if (wrap) begin
        tick_d   = '0;
        period_d = target;
      end else begin
        tick_d = tick_q + 32'd1;
      end

      if (state_q == LAUNCH && !game_over_in) begin
        stagger_d = (stagger_q == STG_LAST) ? '0 : stagger_q + STG_W'(1);
        if (launch_slot && idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
      end
    end else if (state_q == HALT) begin
      pending_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic, evaluated on the values of the cycle being entered
  // ---------------------------------------------------------------------------
  always_comb begin
    col_reset_d = '0;
    fall_tick_d = '0;
    running_d   = (state_d == LAUNCH) || (state_d == RUN);
    if (running_d) begin
      if (state_d == LAUNCH && stagger_d == '0)
        col_reset_d = ONE_COL << idx_d;
      else
        col_reset_d = pending_d & (~pending_d + ONE_COL);
      if (tick_d == period_d - 32'd1)
        fall_tick_d = active_d & ~pending_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q    <= '0;
      pending_q   <= '0;
      tick_q      <= '0;
      stagger_q   <= '0;
      idx_q       <= '0;
      fall_period <= BASE_P;
      col_reset   <= '0;
      fall_tick   <= '0;
      running     <= 1'b0;
    end else begin
      active_q    <= active_d;
      pending_q   <= pending_d;
      tick_q      <= tick_d;
      stagger_q   <= stagger_d;
      idx_q       <= idx_d;
      fall_period <= period_d;
      col_reset   <= col_reset_d;
      fall_tick   <= fall_tick_d;
      running     <= running_d;
    end
  end

  a_one_reset: assert property (@(posedge clock) disable iff (reset) $onehot0(col_reset));
  a_no_pending_tick: assert property (@(posedge clock) disable iff (reset)
                                      (fall_tick & pending_q) == '0);

endmodule
